// File: rtl/dual_core_mem_arbiter_pkg.sv
// rtl/dual_core_mem_arbiter_pkg.sv - shared memory-map constants for the multi-core memory arbiter
//
// Purpose: default bus widths and the RAM/GPIO region split. The cores,
// extmemory and mappedGPIO use the same values.
// Ports: none (package).
package dual_core_mem_arbiter_pkg;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_GPIO_SEL_BIT = 9;

  // One address bit splits the map: clear selects RAM, set selects GPIO.
  localparam logic [DEF_ADDR_W-1:0] RAM_BASE  = 16'h0000;
  localparam logic [DEF_ADDR_W-1:0] GPIO_BASE = 16'h0200;

endpackage

// File: rtl/dual_core_mem_arbiter_rr_arbiter.sv
// rtl/dual_core_mem_arbiter_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: grants the first requester found when scanning upward from ptr,
// wrapping modulo N.
// Ports:
//   req          in  N        request vector
//   ptr          in  log2(N)  highest-priority index for this cycle
//   grant        out N        one-hot grant
//   grant_idx    out log2(N)  index of the granted requester
//   grant_valid  out 1        some requester was granted
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int PW = $clog2(N);

  int            scan;
  logic [PW-1:0] ix;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    scan        = 0;
    ix          = '0;
    for (int k = 0; k < N; k++) begin
      // The modulo keeps the wrap correct for N that is not a power of two.
      scan = (int'(ptr) + k) % N;
      ix   = PW'(scan);
      if (!grant_valid && req[ix]) begin
        grant[ix]   = 1'b1;
        grant_idx   = ix;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// rtl/dual_core_mem_arbiter.sv - round-robin sharing of one RAM and one GPIO among NUM_CPUS cores
//
// Purpose: one access per cycle goes to the slaves. Read data and a
// one-cycle ack return to the core on the following cycle.
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   cpu_memread/cpu_memwrite         per-core request strobes
//   cpu_addr/cpu_writedata           packed per-core address and write data
//   cpu_memdata                      packed registered read data per core
//   cpu_ack                          one-cycle completion pulse per core
//   cpu_stall                        request pending and not yet acked
//   addr/writedata                   granted access toward the slaves
//   memread_ram/memwrite_ram         RAM strobes
//   memread_gpio/memwrite_gpio       GPIO strobes
//   memdata_ram/memdata_gpio         combinational slave read data
module dual_core_mem_arbiter
  import dual_core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CPUS     = 2,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int GPIO_SEL_BIT = DEF_GPIO_SEL_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CPUS-1:0]        cpu_memread,
  input  logic [NUM_CPUS-1:0]        cpu_memwrite,
  input  logic [NUM_CPUS*ADDR_W-1:0] cpu_addr,
  input  logic [NUM_CPUS*DATA_W-1:0] cpu_writedata,
  output logic [NUM_CPUS*DATA_W-1:0] cpu_memdata,
  output logic [NUM_CPUS-1:0]        cpu_ack,
  output logic [NUM_CPUS-1:0]        cpu_stall,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          writedata,
  output logic                       memread_ram,
  output logic                       memwrite_ram,
  output logic                       memread_gpio,
  output logic                       memwrite_gpio,
  input  logic [DATA_W-1:0]          memdata_ram,
  input  logic [DATA_W-1:0]          memdata_gpio
);

  localparam int PW = $clog2(NUM_CPUS);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       g_idx;
  logic [NUM_CPUS-1:0] ack_q;
  logic [NUM_CPUS-1:0] req;
  logic [NUM_CPUS-1:0] grant;
  logic                grant_raw;
  logic                gv;
  logic                sel;
  logic                rd_g;
  logic                wr_g;

  // A core is masked in its ack cycle so that a held request is not
  // taken as a second access.
  assign req = (cpu_memread | cpu_memwrite) & ~ack_q;

  rr_arbiter #(.N(NUM_CPUS)) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (g_idx),
    .grant_valid (grant_raw)
  );

  // Reset kills the grant combinationally, so strobes drop while reset is high.
  assign gv = grant_raw & ~reset;

  assign addr      = gv ? cpu_addr[int'(g_idx)*ADDR_W +: ADDR_W] : '0;
  assign writedata = gv ? cpu_writedata[int'(g_idx)*DATA_W +: DATA_W] : '0;
  assign sel       = addr[GPIO_SEL_BIT];

  // If a core asserts both read and write, the write wins.
  assign wr_g = gv & cpu_memwrite[g_idx];
  assign rd_g = gv & cpu_memread[g_idx] & ~cpu_memwrite[g_idx];

  assign memread_ram   = rd_g & ~sel;
  assign memread_gpio  = rd_g &  sel;
  assign memwrite_ram  = wr_g & ~sel;
  assign memwrite_gpio = wr_g &  sel;

  assign cpu_ack   = ack_q;
  // The granted core still has req set in its grant cycle, so req alone
  // covers both the waiting and the in-flight stall.
  assign cpu_stall = req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      ack_q       <= '0;
      cpu_memdata <= '0;
    end else begin
      ack_q <= gv ? grant : '0;
      if (gv) begin
        ptr <= (g_idx == PW'(NUM_CPUS - 1)) ? '0 : g_idx + 1'b1;
      end
      if (rd_g) begin
        cpu_memdata[int'(g_idx)*DATA_W +: DATA_W] <= sel ? memdata_gpio : memdata_ram;
      end
    end
  end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// tb/tb_dual_core_mem_arbiter.sv - directed self-checking bench for dual_core_mem_arbiter
module tb_dual_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cpu_memread;
  logic [1:0]  cpu_memwrite;
  logic [31:0] cpu_addr;
  logic [15:0] cpu_writedata;
  logic [15:0] cpu_memdata;
  logic [1:0]  cpu_ack;
  logic [1:0]  cpu_stall;
  logic [15:0] addr;
  logic [7:0]  writedata;
  logic        memread_ram, memwrite_ram, memread_gpio, memwrite_gpio;
  logic [7:0]  memdata_ram;
  logic [7:0]  memdata_gpio;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dual_core_mem_arbiter #(
    .NUM_CPUS(2), .ADDR_W(16), .DATA_W(8), .GPIO_SEL_BIT(9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_addr      (cpu_addr),
    .cpu_writedata (cpu_writedata),
    .cpu_memdata   (cpu_memdata),
    .cpu_ack       (cpu_ack),
    .cpu_stall     (cpu_stall),
    .addr          (addr),
    .writedata     (writedata),
    .memread_ram   (memread_ram),
    .memwrite_ram  (memwrite_ram),
    .memread_gpio  (memread_gpio),
    .memwrite_gpio (memwrite_gpio),
    .memdata_ram   (memdata_ram),
    .memdata_gpio  (memdata_gpio)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [7:0]  wd0;
    logic [7:0]  wd1;
    logic [7:0]  ram;
    logic [7:0]  gpio;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    logic [3:0]  e_stb;   // {mr_ram, mw_ram, mr_gpio, mw_gpio}
    logic [1:0]  e_ack;
    logic [1:0]  e_stall;
    logic [15:0] e_md;    // {core1, core0}
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic rst, logic [1:0] rd, logic [1:0] wr,
                              logic [15:0] a0, logic [15:0] a1,
                              logic [7:0] wd0, logic [7:0] wd1,
                              logic [7:0] ram, logic [7:0] gpio,
                              logic [15:0] e_addr, logic [7:0] e_wd,
                              logic [3:0] e_stb, logic [1:0] e_ack,
                              logic [1:0] e_stall, logic [15:0] e_md);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.ram = ram; v.gpio = gpio;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_stb = e_stb;
    v.e_ack = e_ack; v.e_stall = e_stall; v.e_md = e_md;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    cpu_memread   = v.rd;
    cpu_memwrite  = v.wr;
    cpu_addr      = {v.a1, v.a0};
    cpu_writedata = {v.wd1, v.wd0};
    memdata_ram   = v.ram;
    memdata_gpio  = v.gpio;
  endtask

  int          g_exp;
  int          prev_g;
  int          acks0;
  int          acks1;
  logic [7:0]  last_ram;

  initial begin
    cpu_memread = '0; cpu_memwrite = '0; cpu_addr = '0; cpu_writedata = '0;
    memdata_ram = '0; memdata_gpio = '0;
    reset = 1'b1;

    //           rst rd     wr     a0       a1       wd0    wd1    ram    gpio     e_addr   e_wd   e_stb    e_ack  e_stall e_md
    vecs[0]  = mk(1, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 4'b0000, 2'b00, 2'b00, 16'h0000);
    // single RAM read by core 0
    vecs[1]  = mk(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 8'h11, 8'h00, 8'hA5, 8'h00, 16'h0010, 8'h11, 4'b1000, 2'b00, 2'b01, 16'h0000);
    // core 0 holds its request into the ack cycle: masked, no grant
    vecs[2]  = mk(0, 2'b01, 2'b00, 16'h0010, 16'h0000, 8'h11, 8'h00, 8'hA5, 8'h00, 16'h0000, 8'h00, 4'b0000, 2'b01, 2'b00, 16'h00A5);
    // new access by core 0 the cycle after its ack
    vecs[3]  = mk(0, 2'b01, 2'b00, 16'h0020, 16'h0000, 8'h11, 8'h00, 8'h5A, 8'h00, 16'h0020, 8'h11, 4'b1000, 2'b00, 2'b01, 16'h00A5);
    // core 1 writes 0x3C to GPIO 0x0200
    vecs[4]  = mk(0, 2'b00, 2'b10, 16'h0000, 16'h0200, 8'h00, 8'h3C, 8'h00, 8'h00, 16'h0200, 8'h3C, 4'b0001, 2'b01, 2'b10, 16'h005A);
    // core 0 read+write at 0x0005: write only, memdata unchanged
    vecs[5]  = mk(0, 2'b01, 2'b11, 16'h0005, 16'h0200, 8'h77, 8'h3C, 8'hEE, 8'h00, 16'h0005, 8'h77, 4'b0100, 2'b10, 2'b01, 16'h005A);
    vecs[6]  = mk(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 8'h00, 4'b0000, 2'b01, 2'b00, 16'h005A);
    // both read, ptr=1: core 1 to GPIO first, then core 0 to RAM
    vecs[7]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0240, 8'h00, 8'h00, 8'h12, 8'h34, 16'h0240, 8'h00, 4'b0010, 2'b00, 2'b11, 16'h005A);
    vecs[8]  = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0240, 8'h00, 8'h00, 8'h12, 8'h34, 16'h0030, 8'h00, 4'b1000, 2'b10, 2'b01, 16'h345A);
    // reset in a grant cycle: strobes drop, no ack, data cleared
    vecs[9]  = mk(1, 2'b11, 2'b00, 16'h0030, 16'h0240, 8'h00, 8'h00, 8'h12, 8'h34, 16'h0000, 8'h00, 4'b0000, 2'b00, 2'b11, 16'h0000);
    // after release, core 0 wins
    vecs[10] = mk(0, 2'b11, 2'b00, 16'h0030, 16'h0240, 8'h00, 8'h00, 8'h12, 8'h34, 16'h0030, 8'h00, 4'b1000, 2'b00, 2'b11, 16'h0000);

    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d writedata", i), 32'(writedata), 32'(vecs[i].e_wd));
      check($sformatf("v%0d strobes", i),
            32'({memread_ram, memwrite_ram, memread_gpio, memwrite_gpio}), 32'(vecs[i].e_stb));
      check($sformatf("v%0d ack", i), 32'(cpu_ack), 32'(vecs[i].e_ack));
      check($sformatf("v%0d stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d memdata", i), 32'(cpu_memdata), 32'(vecs[i].e_md));
    end

    // Continuous contention: grants alternate starting with core 1 (ptr=1
    // after vector 10), each core acked every second cycle.
    g_exp    = 1;
    prev_g   = 0;
    acks0    = 0;
    acks1    = 0;
    last_ram = 8'h12;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      memdata_ram = 8'h40 + 8'(k);
      @(negedge clk);
      check($sformatf("cont%0d addr", k), 32'(addr), (g_exp == 1) ? 32'h0240 : 32'h0030);
      check($sformatf("cont%0d ack", k), 32'(cpu_ack), (prev_g == 1) ? 32'd2 : 32'd1);
      if (cpu_ack[0]) acks0++;
      if (cpu_ack[1]) acks1++;
      if (prev_g == 0)
        check($sformatf("cont%0d md0", k), 32'(cpu_memdata[7:0]), 32'(last_ram));
      else
        check($sformatf("cont%0d md1", k), 32'(cpu_memdata[15:8]), 32'h34);
      last_ram = memdata_ram;
      prev_g   = g_exp;
      g_exp    = 1 - g_exp;
    end
    check("acks core0", 32'(acks0), 32'd10);
    check("acks core1", 32'(acks1), 32'd10);

    @(posedge clk);
    #1;
    cpu_memread = '0;
    cpu_memwrite = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dual_core_mem_arbiter.md
Name: dual_core_mem_arbiter

Overview:
- Parametrised successor to the single-core address decode. It lets NUM_CPUS mips cores share one extmemory RAM and one mappedGPIO.
- Per cycle it arbitrates the cores' memread/memwrite requests round-robin and decodes the winner's address to RAM or GPIO.
- Read data is returned to each core through a per-core holding register, with a one-cycle ack; a stall is held until then.
- Sits between the cores and the slaves in the dual-core top.

Parameters:
- NUM_CPUS, 2, number of requesting cores (2..8).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- GPIO_SEL_BIT, 9, address bit selecting GPIO (1) or RAM (0).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_memread  in  NUM_CPUS  per-core read request.
- cpu_memwrite  in  NUM_CPUS  per-core write request.
- cpu_addr  in  NUM_CPUS*ADDR_W  packed core addresses; core i at [i*ADDR_W +: ADDR_W].
- cpu_writedata  in  NUM_CPUS*DATA_W  packed write data.
- cpu_memdata  out  NUM_CPUS*DATA_W  packed registered read data.
- cpu_ack  out  NUM_CPUS  one-cycle pulse: access of core i completed.
- cpu_stall  out  NUM_CPUS  core i has a request pending and not yet acked.
- addr  out  ADDR_W  granted address to slaves.
- writedata  out  DATA_W  granted write data.
- memread_ram, memwrite_ram, memread_gpio, memwrite_gpio  out  1 each  decoded slave strobes.
- memdata_ram, memdata_gpio  in  DATA_W each  slave read data; combinational, valid in the strobe cycle.

Behaviour:
- req[i] = (cpu_memread[i] | cpu_memwrite[i]) & ~ack_q[i]. The just-acked core is masked for the cycle in which it sees its ack.
- Arbitration is combinational over req. Priority starts at index ptr and wraps modulo NUM_CPUS.
- At most one grant per cycle. On a grant to core g, ptr <= (g+1) mod NUM_CPUS on the clock edge. With no request, ptr holds.
- Slave side:
  - addr and writedata come from the granted core; with no grant both are 0.
  - sel = addr[GPIO_SEL_BIT].
  - memread_ram = granted read & ~sel; memread_gpio = granted read & sel; the write strobes are decoded the same way.
  - All strobes are 0 when there is no grant.
- Write precedence: if a core asserts both memread and memwrite, it is treated as a write. No read strobe is issued and cpu_memdata is unchanged.
- Completion, on the edge after grant cycle N:
  - ack_q[g] = 1 during cycle N+1; all other ack bits are 0.
  - For a read, cpu_memdata slice g <= (sel ? memdata_gpio : memdata_ram) sampled in cycle N.
  - For a write, slice g holds its value.
- Latency: access issued in the grant cycle, data and ack one cycle later.
  - Minimum spacing for the same core is 2 cycles (grant, ack).
  - Another core may be granted in the ack cycle.
- cpu_stall[i] = req[i] & ~grant[i], plus 1 in the grant cycle until the ack arrives. A core must hold its request and address until cpu_ack[i].
- Contention: with 2 cores both requesting continuously, grants alternate each cycle, A,B,A,B. Each core therefore sees an ack every 2 cycles.
- Reset, asynchronous, takes effect mid-transaction:
  - ptr <= 0, all cpu_ack <= 0, all cpu_memdata <= 0.
  - All slave strobes are forced to 0 while reset is high; an in-flight access is dropped with no ack.
- Bit GPIO_SEL_BIT alone decodes the slave; all other address bits pass through unchanged.

Decomposition:
- Shared header mem_map.vh: GPIO_SEL_BIT default, RAM/GPIO region constants, DATA_W/ADDR_W defaults (shared with the mips top, extmemory and mappedGPIO).
- One sub-module: rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant, grant index, grant_valid), purely combinational.
- The ptr register stays in the parent.

Test Plan:
- Single read: core 0 reads addr 0x0010, RAM returns 0xA5 -> memread_ram=1 in cycle N; cpu_ack[0]=1 and cpu_memdata[7:0]=0xA5 in N+1; no GPIO strobe.
- GPIO write: core 1 writes 0x3C to 0x0200 -> memwrite_gpio=1, writedata=0x3C, addr=0x0200 in N; cpu_ack[1] in N+1; memwrite_ram=0 throughout.
- Contention: both cores read RAM continuously from ptr=0 -> grants 0,1,0,1 on consecutive cycles; each core acked every 2nd cycle; no core starved over 20 cycles.
- Masking: core 0 holds its request one cycle into its ack -> no second grant to core 0 in the ack cycle; a new access is granted the cycle after.
- Read+write both asserted: core 0, addr 0x0005, data 0x77 -> only memwrite_ram strobes; cpu_memdata[7:0] unchanged; ack in N+1.
- Reset mid-op: assert reset in a grant cycle -> strobes drop immediately, no ack, cpu_memdata=0, next grant after release goes to core 0 when both cores request.
